// File: rtl/uart_prog_pkg.sv
// Shared types and defaults for the UART program loader: RX state encoding,
// the end-of-program marker and the default bit period.
package uart_prog_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam logic [31:0] END_MARKER_DEF = 32'h0000_0FFF;

  // 40 MHz / 9600 gives ~4167 on the real chip; the default targets the 4.17 MHz test clock.
  localparam int SYS_CLK_HZ = 4_170_000;
  localparam int BAUD_RATE  = 9600;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  localparam int CLKS_PER_BIT_DEF = clks_per_bit(SYS_CLK_HZ, BAUD_RATE);

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchroniser, start-bit qualification,
// mid-bit sampling of eight data bits (LSB first) and a stop-bit check.
module uart_rx_byte
  import uart_prog_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        state_q, state_d;
  logic             rx_meta, rx_sync;
  logic [CNT_W-1:0] clk_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             sample;

  // Synchroniser flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
    end
  end

  assign sample = (state_q == RX_START) ? (clk_cnt_q == HALF_CNT)
                                        : ((state_q != RX_IDLE) && (clk_cnt_q == FULL_CNT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    case (state_q)
      RX_IDLE:  if (!rx_sync) state_d = RX_START;
      RX_START: if (sample) state_d = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (sample && (bit_cnt_q == 3'd7)) state_d = RX_STOP;
      RX_STOP: begin
        if (sample) begin
          state_d = RX_IDLE;
          if (rx_sync) byte_valid_o = 1'b1;
          else         frame_err_o  = 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
    if (clear_i) begin
      state_d      = RX_IDLE;
      byte_valid_o = 1'b0;
      frame_err_o  = 1'b0;
    end
  end

  // The bit-period counter restarts at every sample point so each bit is timed from the last.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (clear_i || (state_q == RX_IDLE)) begin
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else if (sample) begin
      clk_cnt_q <= '0;
      if (state_q == RX_DATA) begin
        shift_q   <= {rx_sync, shift_q[7:1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
    end else begin
      clk_cnt_q <= clk_cnt_q + CNT_W'(1);
    end
  end

  assign byte_o = shift_q;
  assign busy_o = (state_q != RX_IDLE);

endmodule

// File: rtl/uart_prog_loader.sv
// Program loader: packs received UART bytes little-endian into 32-bit words and
// writes them to instruction memory from address 0 until a marker word or memory full.
module uart_prog_loader
  import uart_prog_pkg::*;
#(
  parameter int          CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int          ADDR_W       = 10,
  parameter logic [31:0] END_MARKER   = END_MARKER_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              prog_en_i,
  input  logic              rx_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              done_o,
  output logic              full_err_o,
  output logic              frame_err_o,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              rx_ferr;
  logic [1:0]        byte_cnt_q;
  logic [23:0]       low_bytes_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       word;
  logic              accept;
  logic              word_done;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (!prog_en_i),
    .rx_i        (rx_i),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .frame_err_o (rx_ferr),
    .busy_o      (busy_o)
  );

  assign accept    = rx_valid && prog_en_i && !done_o;
  assign word_done = accept && (byte_cnt_q == 2'd3);
  assign word      = {rx_byte, low_bytes_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt_q  <= '0;
      low_bytes_q <= '0;
    end else if (!prog_en_i) begin
      byte_cnt_q <= '0;
    end else if (accept) begin
      byte_cnt_q <= byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    low_bytes_q[7:0]   <= rx_byte;
        2'd1:    low_bytes_q[15:8]  <= rx_byte;
        2'd2:    low_bytes_q[23:16] <= rx_byte;
        default: ;
      endcase
    end
  end

  // The write strobe defaults low every cycle, so a pulse already issued still
  // completes when prog_en_i drops; address and data hold between writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      addr_q      <= '0;
      done_o      <= 1'b0;
      full_err_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      mem_we_o <= 1'b0;
      if (!prog_en_i) begin
        addr_q      <= '0;
        done_o      <= 1'b0;
        full_err_o  <= 1'b0;
        frame_err_o <= 1'b0;
      end else begin
        if (rx_ferr) frame_err_o <= 1'b1;
        if (word_done) begin
          if (word == END_MARKER) begin
            done_o <= 1'b1;
          end else begin
            mem_we_o    <= 1'b1;
            mem_addr_o  <= addr_q;
            mem_wdata_o <= word;
            if (addr_q == LAST_ADDR) begin
              done_o     <= 1'b1;
              full_err_o <= 1'b1;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: drives UART frames bit by bit and compares the
// memory writes and status flags against a byte-level model of the loading rules.
module tb_uart_prog_loader;

  localparam int          CPB    = 16;
  localparam int          ADDR_W = 4;
  localparam logic [31:0] MARKER = 32'h0000_0FFF;

  logic              clk_i     = 1'b0;
  logic              rst_ni    = 1'b1;
  logic              prog_en_i = 1'b0;
  logic              rx_i      = 1'b1;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              done_o;
  logic              full_err_o;
  logic              frame_err_o;
  logic              busy_o;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] obs_q[$];

  int          model_addr;
  int          model_cnt;
  logic [31:0] model_word;
  bit          model_done;
  bit          model_full;
  bit          model_ferr;

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (ADDR_W),
    .END_MARKER  (MARKER)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .prog_en_i  (prog_en_i),
    .rx_i       (rx_i),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .done_o     (done_o),
    .full_err_o (full_err_o),
    .frame_err_o(frame_err_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Every cycle the strobe is high counts as one write, so a stretched pulse shows up as an extra entry.
  always @(negedge clk_i) begin
    if (mem_we_o === 1'b1) obs_q.push_back({mem_addr_o, mem_wdata_o});
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelClear();
    model_addr = 0;
    model_cnt  = 0;
    model_word = '0;
    model_done = 0;
    model_full = 0;
    model_ferr = 0;
  endtask

  task automatic modelByte(input logic [7:0] b, input bit good_stop);
    if (!good_stop) begin
      model_ferr = 1;
    end else if (!model_done) begin
      model_word[8*model_cnt +: 8] = b;
      model_cnt++;
      if (model_cnt == 4) begin
        model_cnt = 0;
        if (model_word == MARKER) begin
          model_done = 1;
        end else begin
          exp_q.push_back({ADDR_W'(model_addr), model_word});
          if (model_addr == (1 << ADDR_W) - 1) begin
            model_done = 1;
            model_full = 1;
          end else begin
            model_addr++;
          end
        end
      end
    end
  endtask

  task automatic driveBit(input logic v);
    rx_i = v;
    repeat (CPB) @(negedge clk_i);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit good_stop);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
    driveBit(good_stop);
    rx_i = 1'b1;
    repeat (good_stop ? 4 : 24) @(negedge clk_i);
    modelByte(b, good_stop);
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) applyStimulus(w[8*i +: 8], 1'b1);
  endtask

  function automatic logic [31:0] randWord();
    logic [31:0] w;
    w = $urandom;
    if (w == MARKER) w = w ^ 32'h1;
    return w;
  endfunction

  task automatic checkWrites(input string tag);
    int n;
    checkOutput({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) checkOutput({tag, "_write"}, 64'(obs_q[i]), 64'(exp_q[i]));
    checkOutput({tag, "_done"},  64'(done_o),      64'(model_done));
    checkOutput({tag, "_full"},  64'(full_err_o),  64'(model_full));
    checkOutput({tag, "_ferr"},  64'(frame_err_o), 64'(model_ferr));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic toggleEnable();
    prog_en_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("clear_done", 64'(done_o),      64'(0));
    checkOutput("clear_full", 64'(full_err_o),  64'(0));
    checkOutput("clear_ferr", 64'(frame_err_o), 64'(0));
    prog_en_i = 1'b1;
    modelClear();
    repeat (4) @(negedge clk_i);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_we"},    64'(mem_we_o),    64'(0));
    checkOutput({tag, "_addr"},  64'(mem_addr_o),  64'(0));
    checkOutput({tag, "_wdata"}, 64'(mem_wdata_o), 64'(0));
    checkOutput({tag, "_done"},  64'(done_o),      64'(0));
    checkOutput({tag, "_full"},  64'(full_err_o),  64'(0));
    checkOutput({tag, "_ferr"},  64'(frame_err_o), 64'(0));
    checkOutput({tag, "_busy"},  64'(busy_o),      64'(0));
  endtask

  initial begin
    modelClear();
    #1 rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    checkAllZero("reset");
    rst_ni    = 1'b1;
    prog_en_i = 1'b1;
    repeat (4) @(negedge clk_i);

    $display("[TB] single word");
    sendWord(32'h1234_5678);
    checkOutput("single_addr",  64'(mem_addr_o),  64'(0));
    checkOutput("single_wdata", 64'(mem_wdata_o), 64'h1234_5678);
    checkWrites("single");

    $display("[TB] two words then marker");
    toggleEnable();
    sendWord(32'h0000_0013);
    sendWord(32'hDEAD_BEEF);
    sendWord(MARKER);
    checkWrites("marker");
    sendWord(randWord());
    checkWrites("after_marker");

    $display("[TB] glitch and framing");
    toggleEnable();
    rx_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checkOutput("glitch_busy_high", 64'(busy_o), 64'(1));
    repeat (30) @(negedge clk_i);
    checkOutput("glitch_busy_low", 64'(busy_o), 64'(0));
    checkWrites("glitch");
    applyStimulus(8'($urandom), 1'b0);
    checkWrites("frame_err");
    sendWord(randWord());
    checkWrites("after_frame_err");

    $display("[TB] memory full");
    toggleEnable();
    for (int i = 0; i < (1 << ADDR_W); i++) sendWord(randWord());
    checkOutput("full_last_addr", 64'(mem_addr_o), 64'((1 << ADDR_W) - 1));
    checkWrites("full");
    sendWord(randWord());
    checkWrites("after_full");

    $display("[TB] abort");
    toggleEnable();
    applyStimulus(8'($urandom), 1'b1);
    applyStimulus(8'($urandom), 1'b1);
    toggleEnable();
    sendWord(32'hAABB_CCDD);
    checkOutput("abort_addr",  64'(mem_addr_o),  64'(0));
    checkOutput("abort_wdata", 64'(mem_wdata_o), 64'hAABB_CCDD);
    checkWrites("abort");

    $display("[TB] async reset mid frame");
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    checkOutput("pre_reset_busy", 64'(busy_o), 64'(1));
    #2 rst_ni = 1'b0;
    #1 checkAllZero("async_reset");
    rx_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    modelClear();
    obs_q.delete();
    exp_q.delete();
    repeat (4) @(negedge clk_i);
    sendWord(randWord());
    checkWrites("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
